// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module      : regfile_2r1w
// Description : Synchronous register file, two registered read ports and one
//               write port. Optional hardwired zero register and optional
//               same-cycle write-to-read forwarding.
// Ports       : clk            rising-edge clock
//               reset          synchronous active-high reset
//               we/wa/wd       write enable, address, data
//               re_a/ra_a/rd_a read enable, address, registered data (port A)
//               re_b/ra_b/rd_b read enable, address, registered data (port B)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w #(
  parameter int N        = 8,   // data width
  parameter int AW       = 5,   // address width, DEPTH = 2**AW
  parameter int ZERO_REG = 1,   // 1: register 0 is hardwired to zero
  parameter int BYPASS   = 1    // 1: forward same-cycle write data to reads
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd,
  input  logic          re_a,
  input  logic [AW-1:0] ra_a,
  output logic [N-1:0]  rd_a,
  input  logic          re_b,
  input  logic [AW-1:0] ra_b,
  output logic [N-1:0]  rd_b
);

  localparam int C_DEPTH = 2 ** AW;

  logic [N-1:0] r_regs [C_DEPTH];

  logic         w_wr_ok;
  logic [N-1:0] w_val_a;
  logic [N-1:0] w_val_b;

  // Writes aimed at the hardwired zero register are dropped here, so the
  // forwarding path below never sees them either.
  assign w_wr_ok = we & ~((ZERO_REG != 0) & (wa == '0));

  // Read value selection: zero register wins, then forwarded write data,
  // then the stored (pre-edge) contents.
  always_comb begin
    w_val_a = r_regs[ra_a];
    if ((ZERO_REG != 0) && (ra_a == '0)) begin
      w_val_a = '0;
    end else if ((BYPASS != 0) && w_wr_ok && (wa == ra_a)) begin
      w_val_a = wd;
    end
  end

  always_comb begin
    w_val_b = r_regs[ra_b];
    if ((ZERO_REG != 0) && (ra_b == '0)) begin
      w_val_b = '0;
    end else if ((BYPASS != 0) && w_wr_ok && (wa == ra_b)) begin
      w_val_b = wd;
    end
  end

  // Reset takes priority over any write or read presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wa] <= wd;
      end
      if (re_a) begin
        rd_a <= w_val_a;
      end
      if (re_b) begin
        rd_b <= w_val_b;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// ============================================================================
// Module      : tb_regfile_2r1w
// Description : Self-checking bench for regfile_2r1w. Two instances share one
//               stimulus stream: N=8/AW=5 with zero register and forwarding,
//               and N=32/AW=4 with neither. Each is compared against its own
//               array-based reference model after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        re_a;
  logic [4:0]  ra_a;
  logic        re_b;
  logic [4:0]  ra_b;

  logic [7:0]  rd_a0, rd_b0;
  logic [31:0] rd_a1, rd_b1;

  int checks = 0;
  int errors = 0;

  // Reference state: instance 0 (zero reg + bypass), instance 1 (neither)
  logic [7:0]  m0_regs [32];
  logic [7:0]  m0_a, m0_b;
  logic [31:0] m1_regs [16];
  logic [31:0] m1_a, m1_b;

  always #5 clk = ~clk;

  regfile_2r1w #(.N(8), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .we(we), .wa(wa), .wd(wd[7:0]),
    .re_a(re_a), .ra_a(ra_a), .rd_a(rd_a0),
    .re_b(re_b), .ra_b(ra_b), .rd_b(rd_b0)
  );

  regfile_2r1w #(.N(32), .AW(4), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .we(we), .wa(wa[3:0]), .wd(wd),
    .re_a(re_a), .ra_a(ra_a[3:0]), .rd_a(rd_a1),
    .re_b(re_b), .ra_b(ra_b[3:0]), .rd_b(rd_b1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instance 0: r0 reads zero; a legal write to the same address is visible.
  function automatic logic [7:0] m0_val(input logic [4:0] x);
    if (x == 5'd0) return 8'h00;
    if (we && wa != 5'd0 && wa == x) return wd[7:0];
    return m0_regs[x];
  endfunction

  // Apply current inputs for one clock, advance the models, compare outputs.
  task automatic step();
    if (reset) begin
      for (int i = 0; i < 32; i++) m0_regs[i] = '0;
      for (int i = 0; i < 16; i++) m1_regs[i] = '0;
      m0_a = '0; m0_b = '0; m1_a = '0; m1_b = '0;
    end else begin
      if (re_a) begin m0_a = m0_val(ra_a); m1_a = m1_regs[ra_a[3:0]]; end
      if (re_b) begin m0_b = m0_val(ra_b); m1_b = m1_regs[ra_b[3:0]]; end
      if (we && wa != 5'd0) m0_regs[wa] = wd[7:0];
      if (we) m1_regs[wa[3:0]] = wd;
    end
    @(posedge clk);
    #1;
    check("rd_a0", {24'h0, rd_a0}, {24'h0, m0_a});
    check("rd_b0", {24'h0, rd_b0}, {24'h0, m0_b});
    check("rd_a1", rd_a1, m1_a);
    check("rd_b1", rd_b1, m1_b);
  endtask

  task automatic idle();
    we = 1'b0; re_a = 1'b0; re_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0;
    re_a = 1'b0; ra_a = '0; re_b = 1'b0; ra_b = '0;

    // Reset for two cycles, then every address reads zero on both ports
    step(); step();
    check("reset_rd_a0", {24'h0, rd_a0}, 32'h0);
    check("reset_rd_b1", rd_b1, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      re_a = 1'b1; ra_a = 5'(i); re_b = 1'b1; ra_b = 5'(31 - i);
      step();
      check("reset_scan0", {24'h0, rd_a0}, 32'h0);
    end

    // Plain write then read
    idle(); we = 1'b1; wa = 5'd3; wd = 32'hA5;
    step();
    idle(); re_a = 1'b1; ra_a = 5'd3;
    step();
    check("wr_rd0", {24'h0, rd_a0}, 32'hA5);
    check("wr_rd1", rd_a1, 32'hA5);

    // Same-cycle write and read of r7 (old value 0x11)
    idle(); we = 1'b1; wa = 5'd7; wd = 32'h11;
    step();
    we = 1'b1; wa = 5'd7; wd = 32'h3C;
    re_a = 1'b1; ra_a = 5'd7; re_b = 1'b1; ra_b = 5'd7;
    step();
    check("byp_a0", {24'h0, rd_a0}, 32'h3C);
    check("byp_b0", {24'h0, rd_b0}, 32'h3C);
    check("nobyp_a1", rd_a1, 32'h11);
    check("nobyp_b1", rd_b1, 32'h11);

    // Zero register: write 0xFF to r0 with a same-cycle read on B, then read on A
    idle(); we = 1'b1; wa = 5'd0; wd = 32'hFF; re_b = 1'b1; ra_b = 5'd0;
    step();
    check("zero_b0", {24'h0, rd_b0}, 32'h0);
    check("zero_b1", rd_b1, 32'h0);
    idle(); re_a = 1'b1; ra_a = 5'd0;
    step();
    check("zero_a0", {24'h0, rd_a0}, 32'h0);
    check("zero_a1", rd_a1, 32'hFF);

    // Hold: rd_b keeps 0x11 while disabled and r12 is rewritten
    idle(); we = 1'b1; wa = 5'd12; wd = 32'h11;
    step();
    idle(); re_b = 1'b1; ra_b = 5'd12;
    step();
    check("hold_init0", {24'h0, rd_b0}, 32'h11);
    for (int i = 0; i < 3; i++) begin
      idle(); ra_b = 5'($urandom); we = 1'b1; wa = 5'd12; wd = $urandom;
      step();
      check("hold_b0", {24'h0, rd_b0}, 32'h11);
      check("hold_b1", rd_b1, 32'h11);
    end

    // Reset in the same cycle as a write to r9
    idle(); reset = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h55; re_a = 1'b1; ra_a = 5'd9;
    step();
    check("rstmid_a0", {24'h0, rd_a0}, 32'h0);
    check("rstmid_b0", {24'h0, rd_b0}, 32'h0);
    check("rstmid_a1", rd_a1, 32'h0);
    reset = 1'b0;
    idle(); re_a = 1'b1; ra_a = 5'd9; re_b = 1'b1; ra_b = 5'd9;
    step();
    check("rstmid_r9_0", {24'h0, rd_a0}, 32'h0);
    check("rstmid_r9_1", rd_b1, 32'h0);

    // Randomised run; read addresses often collide with the write address
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(63) == 0);
      we    = $urandom_range(1);
      wa    = 5'($urandom_range(3) == 0 ? 0 : $urandom);
      wd    = $urandom;
      re_a  = $urandom_range(3) != 0;
      re_b  = $urandom_range(3) != 0;
      ra_a  = ($urandom_range(2) == 0) ? wa : 5'($urandom);
      ra_b  = ($urandom_range(2) == 0) ? wa : 5'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
